// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state type and opcode classification for alu_multiciclo.
// Defining ALU_DIV_EN makes OP_DIVU an iterative operation.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iterativa.sv
// alu_iterativa: shared shift-add multiplier / restoring divider with its iteration counter.
// The divide step only exists when ALU_DIV_EN is defined.
module alu_iterativa #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
`ifdef ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_cnt_zero,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntLoad = CW'(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_mq, r_opnd;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_step, w_mq_step;
`ifdef ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_rem, w_trial;
`endif

  // {r_acc, r_mq} is the double-width product (MUL) or {remainder, quotient} (DIVU).
  always_comb begin
    w_sum      = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
    w_acc_step = w_sum[WIDTH:1];
    w_mq_step  = {w_sum[0], r_mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    w_rem   = {r_acc, r_mq[WIDTH-1]};
    w_trial = w_rem - {1'b0, r_opnd};
    if (r_div) begin
      w_acc_step = w_trial[WIDTH] ? w_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_mq_step  = {r_mq[WIDTH-2:0], ~w_trial[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mq   <= '0;
      r_opnd <= '0;
`ifdef ALU_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_cnt <= CntLoad;
      r_acc <= '0;
`ifdef ALU_DIV_EN
      r_div  <= i_div;
      r_mq   <= i_div ? i_a : i_b;
      r_opnd <= i_div ? i_b : i_a;
`else
      r_mq   <= i_b;
      r_opnd <= i_a;
`endif
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= w_acc_step;
      r_mq  <= w_mq_step;
    end
  end

  assign o_cnt_zero = (r_cnt == '0);
  assign o_lo       = r_mq;
  assign o_hi       = r_acc;

endmodule

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with valid/ready handshake and registered result and flags.
// Define ALU_DIV_EN to add unsigned divide on OP 1011; otherwise that code is an unknown op.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dato1,
  input  logic [WIDTH-1:0] dato2,
  input  logic [3:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] datoOut,
  output logic             ZF,
  output logic             CF,
  output logic             VF,
  output logic             NF
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [3:0]       r_op;
  logic             r_zf, r_cf, r_vf, r_nf;
  logic             w_accept, w_finish, w_start, w_cnt_zero;
  logic [WIDTH-1:0] w_it_lo, w_it_hi, w_res;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_cf, w_vf;
`ifdef ALU_DIV_EN
  logic             w_div;
  assign w_div = (OP == OP_DIVU);
`endif

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_start  = w_accept && is_iterative(OP);
  // Single-cycle ops leave the counter at zero, so they finish on the first BUSY cycle.
  assign w_finish = (r_state == BUSY) && w_cnt_zero;

  alu_iterativa #(
    .WIDTH(WIDTH)
  ) u_iterativa (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
`ifdef ALU_DIV_EN
    .i_div     (w_div),
`endif
    .i_a       (dato1),
    .i_b       (dato2),
    .o_cnt_zero(w_cnt_zero),
    .o_lo      (w_it_lo),
    .o_hi      (w_it_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)   w_state_next = BUSY;
      BUSY:    if (w_cnt_zero) w_state_next = DONE;
      DONE:    if (out_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_res  = '0;
    w_cf   = 1'b0;
    w_vf   = 1'b0;
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_diff = {1'b0, r_a} - {1'b0, r_b};
    case (r_op)
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_cf  = w_diff[WIDTH];
        w_vf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLT: w_res = WIDTH'(w_diff[WIDTH]);
      OP_SLL: w_res = r_a << r_b[SHW-1:0];
      OP_SRL: w_res = r_a >> r_b[SHW-1:0];
      OP_MUL: begin
        w_res = w_it_lo;
        w_cf  = |w_it_hi;
      end
`ifdef ALU_DIV_EN
      OP_DIVU: begin
        w_res = w_it_lo;
        w_cf  = (r_b == '0);
      end
`endif
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_res <= '0;
      r_zf  <= 1'b1;
      r_cf  <= 1'b0;
      r_vf  <= 1'b0;
      r_nf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a  <= dato1;
        r_b  <= dato2;
        r_op <= OP;
      end
      if (w_finish) begin
        r_res <= w_res;
        r_zf  <= (w_res == '0);
        r_cf  <= w_cf;
        r_vf  <= w_vf;
        r_nf  <= w_res[WIDTH-1];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign datoOut   = r_res;
  assign ZF        = r_zf;
  assign CF        = r_cf;
  assign VF        = r_vf;
  assign NF        = r_nf;

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, multi-cycle successor to the datapath's combinational 32-bit ALU. Accepts one operation per valid/ready handshake, executes single-cycle logic/arithmetic ops in one clock and iterative multiply (and optionally divide) over WIDTH clocks, then holds a registered result with ZF/CF/VF/NF flags until the consumer accepts it. Sits between the register-file read stage and write-back in the multi-cycle core.

## Interface
- WIDTH, 32, operand/result width; ≥ 8, power of two
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/OP presented
- in_ready  out  1  block can accept (high only in IDLE)
- dato1  in  WIDTH  operand A
- dato2  in  WIDTH  operand B
- OP  in  4  operation code
- out_valid  out  1  datoOut/flags valid
- out_ready  in  1  consumer accepts result
- datoOut  out  WIDTH  registered result
- ZF, CF, VF, NF  out  1 each  zero, carry/borrow, signed overflow, negative

## Operation
- OP map: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (unsigned, result 1/0); 1100 NOR; 1000 SLL; 1001 SRL (shift amount dato2[$clog2(WIDTH)-1:0]); 1010 MUL (unsigned, low WIDTH bits); 1011 DIVU (only with macro); any other → datoOut 0.
- FSM: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch dato1/dato2/OP. Single-cycle op → compute, go DONE. MUL/DIVU → load iteration counter = WIDTH, go BUSY.
  - BUSY: one shift-add (MUL) or restore-subtract (DIVU) step per cycle; counter decrements; at counter reaching 0, write result and flags, go DONE.
  - DONE: out_valid=1; datoOut/flags stable. On out_ready, go IDLE.
- Flags computed from final datoOut: ZF = (datoOut==0); NF = datoOut[WIDTH-1]. CF: ADD carry-out; SUB borrow (dato1<dato2 unsigned); MUL: 1 if high WIDTH bits of the 2·WIDTH product nonzero; else 0. VF: ADD/SUB signed overflow; else 0.
- Arithmetic wraps modulo 2^WIDTH; internal adder WIDTH+1 bits for carry.
- Reset (any state, mid-iteration included): state IDLE, datoOut 0, ZF 1, CF/VF/NF 0, out_valid 0, in_ready 1, counter 0; operation abandoned.
- in_valid ignored while not IDLE; inputs need not be held after acceptance.

## Timing
- Handshake transfer occurs on a rising edge with valid and ready both high.
- Single-cycle ops: accepted at edge N → out_valid high after edge N+1.
- MUL/DIVU: accepted at edge N → out_valid high after edge N+1+WIDTH.
- out_ready may be high early; result consumed at first edge with out_valid && out_ready; in_ready rises the following cycle (no accept in DONE → max throughput 1 op / 2 cycles for single-cycle ops).
- No combinational path from inputs to outputs.

## Configuration
- ALU_DIV_EN defined: OP 1011 = unsigned restoring divide, datoOut = quotient, WIDTH BUSY cycles; divide by zero → quotient all ones, CF=1, no hang.
- Undefined: divider hardware absent; 1011 treated as unknown op (single cycle, datoOut 0, ZF 1).

## Structure
- Shared package alu_pkg: OP encoding constants (OP_AND … OP_DIVU), state typedef (IDLE/BUSY/DONE).
- One sub-module: alu_iterativa (shared shift-add / restoring-divide datapath with its counter); single-cycle ops and FSM stay in the top.

## Test plan
- ADD 0xFFFF_FFFF + 0x1 → datoOut 0, ZF 1, CF 1, VF 0, out_valid one cycle after accept.
- SUB 0x7FFF_FFFF − 0xFFFF_FFFF → 0x8000_0000, VF 1, NF 1, CF 1.
- MUL 0x0001_0000 × 0x0001_0000 → datoOut 0, CF 1, ZF 1, out_valid exactly 33 cycles after accept; in_ready 0 throughout.
- out_ready held low 5 cycles after SLT 3<5 → datoOut 1 stable, out_valid held, new in_valid ignored.
- rst_n pulsed mid-MUL (cycle 10) → all outputs at reset values immediately; next ADD 2+3 → 5.
- With ALU_DIV_EN: DIVU 100/7 → 14 after 33 cycles; DIVU x/0 → 0xFFFF_FFFF, CF 1. Without: OP 1011 → 0, ZF 1, latency 1.
